// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the core's
// load/store port. Accepts one request, waits WAIT_STATES cycles, performs
// a byte/half/word access on an internal word RAM and returns one response.
// Misaligned, illegal-size and out-of-range accesses are rejected with
// rsp_err and leave the RAM untouched.
module dmem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  d_rw,
  input  logic [31:0]           daddr,
  input  logic [DATA_WIDTH-1:0] ddata_w,
  input  logic [1:0]            d_size,
  input  logic                  d_unsigned,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] ddata_r,
  output logic                  rsp_err
);

  localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [MEM_DEPTH];

  logic        accept_s, enter_resp_s, we_s, err_s, range_err_s;
  logic        cur_rw_s, cur_uns_s;
  logic [31:0] cur_addr_s, cur_wdata_s, off_s;
  logic [1:0]  cur_size_s;
  logic [IDX_W-1:0] idx_s;
  logic [3:0]  be_s;
  logic [31:0] wlane_s, word_s, rd_ext_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // The access happens on the edge entering RESP; with zero wait states that
  // edge is the accept edge, so the live inputs stand in for the latched ones.
  always_comb begin
    if (state_q == IDLE) begin
      cur_rw_s    = d_rw;
      cur_addr_s  = daddr;
      cur_wdata_s = ddata_w;
      cur_size_s  = d_size;
      cur_uns_s   = d_unsigned;
    end else begin
      cur_rw_s    = rw_q;
      cur_addr_s  = addr_q;
      cur_wdata_s = wdata_q;
      cur_size_s  = size_q;
      cur_uns_s   = uns_q;
    end
  end

  assign off_s       = cur_addr_s - BASE_ADDR;
  assign idx_s       = off_s[IDX_W+1:2];
  assign range_err_s = (cur_addr_s < BASE_ADDR) || ({2'b00, off_s[31:2]} >= 32'(MEM_DEPTH));

  // Alignment/size/range checks on the request being serviced.
  always_comb begin
    err_s = range_err_s;
    case (cur_size_s)
      2'b00:   err_s = range_err_s;
      2'b01:   err_s = range_err_s || off_s[0];
      2'b10:   err_s = range_err_s || (off_s[1:0] != 2'b00);
      default: err_s = 1'b1;
    endcase
  end

  // Byte enables and store data replicated onto the addressed lanes.
  always_comb begin
    be_s    = 4'b1111;
    wlane_s = cur_wdata_s;
    case (cur_size_s)
      2'b00: begin
        be_s    = 4'b0001 << off_s[1:0];
        wlane_s = {4{cur_wdata_s[7:0]}};
      end
      2'b01: begin
        be_s    = off_s[1] ? 4'b1100 : 4'b0011;
        wlane_s = {2{cur_wdata_s[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wlane_s = cur_wdata_s;
      end
    endcase
  end

  assign word_s = mem_q[idx_s];
  assign half_s = off_s[1] ? word_s[31:16] : word_s[15:0];

  // Lane extraction and sign/zero extension for loads.
  always_comb begin
    byte_s   = word_s[7:0];
    rd_ext_s = word_s;
    case (off_s[1:0])
      2'b00:   byte_s = word_s[7:0];
      2'b01:   byte_s = word_s[15:8];
      2'b10:   byte_s = word_s[23:16];
      default: byte_s = word_s[31:24];
    endcase
    case (cur_size_s)
      2'b00:   rd_ext_s = cur_uns_s ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
      2'b01:   rd_ext_s = cur_uns_s ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
      default: rd_ext_s = word_s;
    endcase
  end

  // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE, counting wait states.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    enter_resp_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_d      = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept_s  = req_valid && (state_q == IDLE);
  assign we_s      = enter_resp_s && cur_rw_s && !err_s && !RESET;
  assign req_ready = (state_q == IDLE) && !RESET;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign ddata_r   = rdata_q;

  // Control state, request latch and held response registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= enter_resp_s;
      if (accept_s) begin
        rw_q    <= d_rw;
        addr_q  <= daddr;
        wdata_q <= ddata_w;
        size_q  <= d_size;
        uns_q   <= d_unsigned;
      end
      if (enter_resp_s) begin
        rsp_err_q <= err_s;
        rdata_q   <= (err_s || cur_rw_s) ? 32'd0 : rd_ext_s;
      end
    end
  end

  // RAM write port with per-lane enables; contents survive reset.
  always_ff @(posedge CLK) begin
    if (we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) mem_q[idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 1 and 3 wait states) share
// the request bus; each has its own valid and reset. A byte-array model
// predicts responses, and a compare process checks every cycle.
module tb_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [2:0]        rst = 3'b111;
  logic [2:0]        rv  = 3'b000;
  logic [2:0]        rdy, rspv, rerr;
  logic [2:0][31:0]  rdat;
  logic              d_rw = 1'b0;
  logic [31:0]       daddr = 32'd0, ddata_w = 32'd0;
  logic [1:0]        d_size = 2'b00;
  logic              d_unsigned = 1'b0;

  int nvec = 0, nerr = 0, cyc = 0;
  bit          pend [3];
  int          pdue [3];
  logic        perr [3];
  logic [31:0] pdat [3];
  int          busy_from [3];
  int          busy_to   [3];
  logic [7:0]  mm [3][4096];

  dmem_responder #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_ws0 (
    .CLK(CLK), .RESET(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]),
    .d_rw(d_rw), .daddr(daddr), .ddata_w(ddata_w), .d_size(d_size), .d_unsigned(d_unsigned),
    .rsp_valid(rspv[0]), .ddata_r(rdat[0]), .rsp_err(rerr[0]));

  dmem_responder #(.MEM_DEPTH(DEPTH), .WAIT_STATES(1), .BASE_ADDR(BASE)) u_ws1 (
    .CLK(CLK), .RESET(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]),
    .d_rw(d_rw), .daddr(daddr), .ddata_w(ddata_w), .d_size(d_size), .d_unsigned(d_unsigned),
    .rsp_valid(rspv[1]), .ddata_r(rdat[1]), .rsp_err(rerr[1]));

  dmem_responder #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3), .BASE_ADDR(BASE)) u_ws3 (
    .CLK(CLK), .RESET(rst[2]), .req_valid(rv[2]), .req_ready(rdy[2]),
    .d_rw(d_rw), .daddr(daddr), .ddata_w(ddata_w), .d_size(d_size), .d_unsigned(d_unsigned),
    .rsp_valid(rspv[2]), .ddata_r(rdat[2]), .rsp_err(rerr[2]));

  // cycle index: value of cyc after the posedge that starts a cycle
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int ws(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One request on instance k; model updated at acceptance. Returns the
  // model's expected read data and error flag.
  task automatic issue(input int k, input logic rw, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic un, input bit abandon,
                       output logic [31:0] mexp, output logic merr);
    int t, off, n;
    logic [31:0] v;
    @(negedge CLK);
    d_rw = rw; daddr = a; ddata_w = wd; d_size = sz; d_unsigned = un; rv[k] = 1'b1;
    t = 0;
    while (!rdy[k] && t < 50) begin
      @(negedge CLK);
      t++;
    end
    mexp = 32'd0;
    merr = 1'b0;
    if (!rdy[k]) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout[%0d]: got ready=0, expected ready=1", k);
      rv[k] = 1'b0;
      return;
    end
    merr = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
           || (a < BASE) || (((a - BASE) >> 2) >= DEPTH);
    if (!merr && !abandon) begin
      off = int'(a - BASE);
      n   = 1 << sz;
      if (rw) begin
        for (int i = 0; i < n; i++) mm[k][off+i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mm[k][off+i];
        if (n == 1 && !un) v = {{24{v[7]}}, v[7:0]};
        if (n == 2 && !un) v = {{16{v[15]}}, v[15:0]};
        mexp = v;
      end
    end
    if (!abandon) begin
      pend[k] = 1'b1;
      pdue[k] = cyc + ws(k) + 1;
      perr[k] = merr;
      pdat[k] = mexp;
    end
    busy_from[k] = cyc;
    busy_to[k]   = cyc + ws(k) + 1;
    @(posedge CLK);
  endtask

  task automatic st(input int k, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] m; logic e;
    issue(k, 1'b1, a, wd, sz, 1'b0, 1'b0, m, e);
  endtask

  task automatic ld(input int k, input logic [31:0] a, input logic [1:0] sz, input logic un,
                    output logic [31:0] m);
    logic e;
    issue(k, 1'b0, a, 32'd0, sz, un, 1'b0, m, e);
  endtask

  task automatic drop(input int k);
    @(negedge CLK);
    rv[k] = 1'b0;
  endtask

  // Per-cycle comparison of every instance against the model.
  initial begin
    logic exp_v, exp_r;
    for (int k = 0; k < 3; k++) begin
      pend[k] = 1'b0; busy_from[k] = 0; busy_to[k] = -1;
    end
    forever begin
      @(negedge CLK);
      #2;
      for (int k = 0; k < 3; k++) begin
        exp_v = pend[k] && (cyc == pdue[k]);
        chk($sformatf("rsp_valid[%0d]", k), {31'd0, rspv[k]}, {31'd0, exp_v});
        if (exp_v) begin
          chk($sformatf("rsp_err[%0d]", k), {31'd0, rerr[k]}, {31'd0, perr[k]});
          chk($sformatf("ddata_r[%0d]", k), rdat[k], pdat[k]);
          pend[k] = 1'b0;
        end
        exp_r = !rst[k] && !(cyc > busy_from[k] && cyc <= busy_to[k]);
        chk($sformatf("req_ready[%0d]", k), {31'd0, rdy[k]}, {31'd0, exp_r});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m;
    logic e;
    repeat (3) @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_rsp_valid[%0d]", k), {31'd0, rspv[k]}, 32'd0);
      chk($sformatf("reset_rsp_err[%0d]", k), {31'd0, rerr[k]}, 32'd0);
      chk($sformatf("reset_ddata_r[%0d]", k), rdat[k], 32'd0);
    end
    rst = 3'b000;

    // word store then load, one wait state
    st(1, 32'h10, 32'hDEADBEEF, 2'b10); drop(1);
    ld(1, 32'h10, 2'b10, 1'b0, m); drop(1);
    chk("pin_ld_word", m, 32'hDEADBEEF);

    // byte store over a word, signed/unsigned byte and word reads
    st(1, 32'h10, 32'h11223344, 2'b10);
    st(1, 32'h13, 32'h00000080, 2'b00);
    ld(1, 32'h13, 2'b00, 1'b0, m); chk("pin_lb_signed", m, 32'hFFFFFF80);
    ld(1, 32'h13, 2'b00, 1'b1, m); chk("pin_lb_unsigned", m, 32'h00000080);
    ld(1, 32'h10, 2'b10, 1'b0, m); chk("pin_lw_after_sb", m, 32'h80223344);

    // half store to the upper half, signed half read, lower half untouched
    st(1, 32'h20, 32'h12345678, 2'b10);
    st(1, 32'h22, 32'h0000ABCD, 2'b01);
    ld(1, 32'h22, 2'b01, 1'b0, m); chk("pin_lh_signed", m, 32'hFFFFABCD);
    ld(1, 32'h20, 2'b10, 1'b0, m); chk("pin_lw_after_sh", m, 32'hABCD5678);
    ld(1, 32'h21, 2'b00, 1'b1, m); chk("pin_lbu_lane1", m, 32'h00000056);
    drop(1);

    // rejected accesses leave word 0 intact
    st(1, 32'h0, 32'h55667788, 2'b10);
    issue(1, 1'b0, 32'h2, 32'd0, 2'b10, 1'b0, 1'b0, m, e); chk("pin_err_lw_misaligned", {31'd0, e}, 32'd1);
    issue(1, 1'b1, 32'h1, 32'hFFFF, 2'b01, 1'b0, 1'b0, m, e); chk("pin_err_sh_misaligned", {31'd0, e}, 32'd1);
    issue(1, 1'b1, 32'h0, 32'hFFFFFFFF, 2'b11, 1'b0, 1'b0, m, e); chk("pin_err_size", {31'd0, e}, 32'd1);
    issue(1, 1'b1, 32'h1000, 32'hA5A5A5A5, 2'b10, 1'b0, 1'b0, m, e); chk("pin_err_range", {31'd0, e}, 32'd1);
    ld(1, 32'h0, 2'b10, 1'b0, m); chk("pin_ram_unchanged", m, 32'h55667788);
    drop(1);

    // zero wait states, valid held high across requests
    st(0, 32'h100, 32'h0BADF00D, 2'b10);
    st(0, 32'h101, 32'h000000EE, 2'b00);
    ld(0, 32'h100, 2'b10, 1'b0, m); chk("pin_ws0_word", m, 32'h0BADEE0D);
    ld(0, 32'h102, 2'b01, 1'b1, m); chk("pin_ws0_lhu", m, 32'h00000BAD);
    issue(0, 1'b0, 32'h103, 32'd0, 2'b01, 1'b0, 1'b0, m, e);
    drop(0);

    // three wait states, valid held high across requests
    st(2, 32'h40, 32'hCAFEF00D, 2'b10);
    st(2, 32'h44, 32'h00008001, 2'b01);
    ld(2, 32'h44, 2'b01, 1'b0, m); chk("pin_ws3_lh", m, 32'hFFFF8001);
    drop(2);

    // reset during the second wait cycle drops the store and its response
    issue(2, 1'b1, 32'h40, 32'h0BADBEEF, 2'b10, 1'b0, 1'b1, m, e);
    @(negedge CLK); rv[2] = 1'b0;
    @(negedge CLK); rst[2] = 1'b1; busy_to[2] = cyc;
    @(negedge CLK); rst[2] = 1'b0;
    #1 chk("ready_after_reset", {31'd0, rdy[2]}, 32'd1);
    ld(2, 32'h40, 2'b10, 1'b0, m); chk("pin_abandoned_write", m, 32'hCAFEF00D);
    drop(2);

    repeat (8) @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      if (pend[k]) begin
        nvec++; nerr++;
        $display("FAIL drain[%0d]: got response pending, expected none", k);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
